// File: rtl/led_pattern_engine_pkg.sv
// Shared encodings for the LED pattern engine: motion modes, shift direction, fill phase.
// Pure type definitions with no latency and no backpressure.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE   = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_FILL     = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef enum logic {
        PHASE_FILL  = 1'b0,
        PHASE_DRAIN = 1'b1
    } phase_t;

endpackage

// File: rtl/led_pattern_engine_if.sv
// Control and LED-output bundle of the pattern engine; the master drives controls and the slave drives LEDs.
// Plain wires with no latency; there is no backpressure, so steps are never stalled by the consumer.
interface led_pattern_engine_if #(
    parameter int N_LEDS = 4,
    parameter int CNT_W  = 32
);
    logic              i_enable;
    logic [1:0]        i_mode;
    logic              i_dir;
    logic [CNT_W-1:0]  i_period;
    logic              i_load;
    logic [N_LEDS-1:0] i_load_pattern;
    logic [N_LEDS-1:0] o_leds;
    logic              o_step;
    logic              o_wrap;

    modport master (
        output i_enable, i_mode, i_dir, i_period, i_load, i_load_pattern,
        input  o_leds, o_step, o_wrap
    );

    modport slave (
        input  i_enable, i_mode, i_dir, i_period, i_load, i_load_pattern,
        output o_leds, o_step, o_wrap
    );
endinterface

// File: rtl/led_pattern_engine_tick.sv
// Step prescaler: o_tick is combinational from the count, high every i_period+1 enabled cycles.
// No backpressure; i_enable low freezes the count exactly and i_clear restarts it from zero.
module led_tick_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_period,
    output logic             o_tick
);

    logic [CNT_W-1:0] cnt;

    // Comparing with >= lets a period lowered below the running count tick at once.
    assign o_tick = i_enable && (cnt >= i_period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (i_clear || o_tick) begin
            cnt <= '0;
        end else if (i_enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern register with prescaled stepping in rotate, ping-pong, fill/drain or hold modes; outputs update one edge after a tick.
// No backpressure: steps are free-running; a load overrides any step and restarts the prescaler.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int                N_LEDS      = 4,
    parameter int                CNT_W       = 32,
    parameter logic [N_LEDS-1:0] RST_PATTERN = {{(N_LEDS-1){1'b0}}, 1'b1}
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_engine_if.slave  bus
);

    logic [N_LEDS-1:0] leds_q;
    logic              step_q;
    logic              wrap_q;
    dir_t              pp_dir_q;
    phase_t            fill_phase_q;

    logic              tick;
    logic [N_LEDS-1:0] nxt_leds;
    logic              nxt_wrap;
    dir_t              nxt_pp_dir;
    phase_t            nxt_phase;
    logic              fill_bit;

    led_tick_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .i_enable (bus.i_enable),
        .i_clear  (bus.i_load),
        .i_period (bus.i_period),
        .o_tick   (tick)
    );

    always_comb begin
        nxt_leds   = leds_q;
        nxt_wrap   = 1'b0;
        nxt_pp_dir = pp_dir_q;
        nxt_phase  = fill_phase_q;
        fill_bit   = 1'b0;
        case (mode_t'(bus.i_mode))
            MODE_ROTATE: begin
                if (dir_t'(bus.i_dir) == DIR_LEFT) begin
                    nxt_leds = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                    nxt_wrap = leds_q[N_LEDS-1];
                end else begin
                    nxt_leds = {leds_q[0], leds_q[N_LEDS-1:1]};
                    nxt_wrap = leds_q[0];
                end
            end
            MODE_PINGPONG: begin
                // Bouncing off an edge reverses within the same step, so the lit bit never stalls.
                if (pp_dir_q == DIR_LEFT) begin
                    if (leds_q[N_LEDS-1]) begin
                        nxt_pp_dir = DIR_RIGHT;
                        nxt_leds   = leds_q >> 1;
                        nxt_wrap   = 1'b1;
                    end else begin
                        nxt_leds = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        nxt_pp_dir = DIR_LEFT;
                        nxt_leds   = leds_q << 1;
                        nxt_wrap   = 1'b1;
                    end else begin
                        nxt_leds = leds_q >> 1;
                    end
                end
            end
            MODE_FILL: begin
                fill_bit = (fill_phase_q == PHASE_FILL);
                if (fill_phase_q == PHASE_FILL && (&leds_q)) begin
                    nxt_phase = PHASE_DRAIN;
                    fill_bit  = 1'b0;
                    nxt_wrap  = 1'b1;
                end else if (fill_phase_q == PHASE_DRAIN && !(|leds_q)) begin
                    nxt_phase = PHASE_FILL;
                    fill_bit  = 1'b1;
                    nxt_wrap  = 1'b1;
                end
                if (dir_t'(bus.i_dir) == DIR_LEFT) begin
                    nxt_leds = {leds_q[N_LEDS-2:0], fill_bit};
                end else begin
                    nxt_leds = {fill_bit, leds_q[N_LEDS-1:1]};
                end
            end
            default: begin
                nxt_leds = leds_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q       <= RST_PATTERN;
            step_q       <= 1'b0;
            wrap_q       <= 1'b0;
            pp_dir_q     <= DIR_LEFT;
            fill_phase_q <= PHASE_FILL;
        end else if (bus.i_load) begin
            leds_q       <= bus.i_load_pattern;
            step_q       <= 1'b0;
            wrap_q       <= 1'b0;
            pp_dir_q     <= dir_t'(bus.i_dir);
            fill_phase_q <= PHASE_FILL;
        end else if (tick) begin
            leds_q       <= nxt_leds;
            step_q       <= 1'b1;
            wrap_q       <= nxt_wrap;
            pp_dir_q     <= nxt_pp_dir;
            fill_phase_q <= nxt_phase;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.o_leds = leds_q;
    assign bus.o_step = step_q;
    assign bus.o_wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: stimulus queues expected steps, a monitor pops them on o_step.
// Each expected step carries its pattern, wrap flag and cycle gap since the last step or load (0 = unchecked).
module tb_led_pattern_engine;
    import led_pkg::*;

    localparam int N  = 4;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;

    led_pattern_engine_if #(.N_LEDS(N), .CNT_W(CW)) bus ();

    led_pattern_engine #(.N_LEDS(N), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] leds;
        logic         wrap;
        int           gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_load_cyc = 0;
    int   last_step_cyc = 0;
    int   ref_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_step(input logic [N-1:0] l, input logic w, input int g);
        exp_t e;
        e.leds = l;
        e.wrap = w;
        e.gap  = g;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.i_load) last_load_cyc <= cyc + 1;
    end

    // Monitor: every o_step pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step actual leds=%b required=no step", bus.o_leds);
                end else begin
                    mon_e   = exp_q.pop_front();
                    ref_cyc = (last_step_cyc > last_load_cyc) ? last_step_cyc : last_load_cyc;
                    check("step_leds", 32'(bus.o_leds), 32'(mon_e.leds));
                    check("step_wrap", 32'(bus.o_wrap), 32'(mon_e.wrap));
                    if (mon_e.gap != 0) check("step_gap", 32'(cyc - ref_cyc), 32'(mon_e.gap));
                end
                last_step_cyc <= cyc;
            end else if (bus.o_wrap) begin
                checks++;
                errors++;
                $display("FAIL wrap_without_step actual o_wrap=1 required=0");
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                = 1'b1;
        bus.i_enable       = 1'b0;
        bus.i_mode         = MODE_ROTATE;
        bus.i_dir          = DIR_LEFT;
        bus.i_period       = 32'd2;
        bus.i_load         = 1'b0;
        bus.i_load_pattern = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_leds", 32'(bus.o_leds), 32'h1);
        check("reset_step", 32'(bus.o_step), 32'h0);
        check("reset_wrap", 32'(bus.o_wrap), 32'h0);

        // Load while disabled, then an async reset between clock edges.
        bus.i_load         = 1'b1;
        bus.i_load_pattern = 4'b1010;
        @(negedge clk);
        bus.i_load = 1'b0;
        check("load_disabled_leds", 32'(bus.o_leds), 32'hA);
        #2 rst = 1'b1;
        #1;
        check("async_rst_leds", 32'(bus.o_leds), 32'h1);
        check("async_rst_step", 32'(bus.o_step), 32'h0);
        check("async_rst_wrap", 32'(bus.o_wrap), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Rotate left, period 2, with a 5-cycle freeze one cycle after the second step.
        expect_step(4'b0010, 1'b0, 0);
        expect_step(4'b0100, 1'b0, 3);
        expect_step(4'b1000, 1'b0, 8);
        expect_step(4'b0001, 1'b1, 3);
        bus.i_enable = 1'b1;
        repeat (7) @(negedge clk);
        bus.i_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("freeze_leds", 32'(bus.o_leds), 32'h4);
        bus.i_enable = 1'b1;
        repeat (5) @(negedge clk);
        bus.i_enable = 1'b0;
        #1 check("rotate_drained", 32'(exp_q.size()), 32'h0);

        // Ping-pong from 0001; i_dir flips after the load and must be ignored.
        expect_step(4'b0010, 1'b0, 1);
        expect_step(4'b0100, 1'b0, 1);
        expect_step(4'b1000, 1'b0, 1);
        expect_step(4'b0100, 1'b1, 1);
        expect_step(4'b0010, 1'b0, 1);
        expect_step(4'b0001, 1'b0, 1);
        expect_step(4'b0010, 1'b1, 1);
        bus.i_mode         = MODE_PINGPONG;
        bus.i_dir          = DIR_LEFT;
        bus.i_period       = 32'd0;
        bus.i_load         = 1'b1;
        bus.i_load_pattern = 4'b0001;
        bus.i_enable       = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        bus.i_dir  = DIR_RIGHT;
        repeat (7) @(negedge clk);
        bus.i_enable = 1'b0;
        #1 check("pingpong_drained", 32'(exp_q.size()), 32'h0);

        // Fill then drain, shifting in from the LSB.
        expect_step(4'b0001, 1'b0, 1);
        expect_step(4'b0011, 1'b0, 1);
        expect_step(4'b0111, 1'b0, 1);
        expect_step(4'b1111, 1'b0, 1);
        expect_step(4'b1110, 1'b1, 1);
        expect_step(4'b1100, 1'b0, 1);
        expect_step(4'b1000, 1'b0, 1);
        expect_step(4'b0000, 1'b0, 1);
        expect_step(4'b0001, 1'b1, 1);
        bus.i_mode         = MODE_FILL;
        bus.i_dir          = DIR_LEFT;
        bus.i_load         = 1'b1;
        bus.i_load_pattern = 4'b0000;
        bus.i_enable       = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        repeat (9) @(negedge clk);
        bus.i_enable = 1'b0;
        #1 check("fill_drained", 32'(exp_q.size()), 32'h0);

        // Load landing on a tick cycle suppresses the step and restarts the count.
        expect_step(4'b0010, 1'b0, 3);
        expect_step(4'b0101, 1'b1, 3);
        bus.i_mode         = MODE_ROTATE;
        bus.i_dir          = DIR_LEFT;
        bus.i_period       = 32'd2;
        bus.i_load         = 1'b1;
        bus.i_load_pattern = 4'b0001;
        bus.i_enable       = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_load         = 1'b1;
        bus.i_load_pattern = 4'b1010;
        @(negedge clk);
        bus.i_load = 1'b0;
        check("load_tick_leds", 32'(bus.o_leds), 32'hA);
        check("load_tick_step", 32'(bus.o_step), 32'h0);
        check("load_tick_wrap", 32'(bus.o_wrap), 32'h0);
        repeat (3) @(negedge clk);
        bus.i_enable = 1'b0;
        #1 check("load_drained", 32'(exp_q.size()), 32'h0);

        // Hold for three ticks, then rotate right.
        expect_step(4'b0100, 1'b0, 1);
        expect_step(4'b0100, 1'b0, 1);
        expect_step(4'b0100, 1'b0, 1);
        expect_step(4'b0010, 1'b0, 1);
        bus.i_mode         = MODE_HOLD;
        bus.i_dir          = DIR_RIGHT;
        bus.i_period       = 32'd0;
        bus.i_load         = 1'b1;
        bus.i_load_pattern = 4'b0100;
        bus.i_enable       = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_mode = MODE_ROTATE;
        @(negedge clk);
        bus.i_enable = 1'b0;
        #1 check("hold_drained", 32'(exp_q.size()), 32'h0);
        repeat (3) @(negedge clk);
        check("final_leds", 32'(bus.o_leds), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
